led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_mode_ctrl.sv | 96 +++++++++
 tb/tb_led_mode_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// Four-LED pattern generator: a mode FSM (flash / run left / run right / bounce)
// driven by a free-running step timer that can be paused.
module led_mode_ctrl #(
  parameter int CNT_TICK = 24_999_999
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       next_mode,
  input  logic       pause,
  output logic [3:0] leds,
  output logic [1:0] mode,
  output logic       tick
);
  localparam logic [1:0]  FLASH   = 2'd0;
  localparam logic [1:0]  RUN_L   = 2'd1;
  localparam logic [1:0]  RUN_R   = 2'd2;
  localparam logic [1:0]  BOUNCE  = 2'd3;
  localparam logic        DIR_L   = 1'b0;
  localparam logic        DIR_R   = 1'b1;
  localparam logic [24:0] CNT_MAX = 25'(CNT_TICK);

  logic [24:0] cnt;
  logic        dir;
  logic        step;
  logic [1:0]  mode_nxt;
  logic [3:0]  init_pat;
  logic [3:0]  step_pat;
  logic [3:0]  rol;
  logic [3:0]  ror;
  logic        dir_nxt;
  logic        one_lit;

  // A mode change on the terminal count wins: the step is dropped entirely.
  assign step     = (cnt == CNT_MAX) && !pause && !next_mode;
  assign mode_nxt = mode + 2'd1;
  assign rol      = {leds[2:0], leds[3]};
  assign ror      = {leds[0], leds[3:1]};

  always_comb begin
    one_lit = 1'b0;
    case (leds)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_lit = 1'b1;
      default:                            one_lit = 1'b0;
    endcase
  end

  always_comb begin
    init_pat = 4'b1110;
    case (mode_nxt)
      FLASH:   init_pat = 4'b1111;
      RUN_R:   init_pat = 4'b0111;
      default: init_pat = 4'b1110;
    endcase
  end

  // Out-of-sequence patterns fold back to the mode's start value on the next step.
  always_comb begin
    step_pat = leds;
    dir_nxt  = dir;
    case (mode)
      FLASH:  step_pat = (leds == 4'b0000) ? 4'b1111 : 4'b0000;
      RUN_L:  step_pat = one_lit ? rol : 4'b1110;
      RUN_R:  step_pat = one_lit ? ror : 4'b0111;
      BOUNCE: begin
        step_pat = !one_lit ? 4'b1110 : (dir == DIR_L) ? rol : ror;
        if (step_pat == 4'b0111)      dir_nxt = DIR_R;
        else if (step_pat == 4'b1110) dir_nxt = DIR_L;
      end
      default: step_pat = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      mode <= FLASH;
      leds <= 4'b1111;
      cnt  <= '0;
      tick <= 1'b0;
      dir  <= DIR_L;
    end else begin
      tick <= step;
      if (next_mode) begin
        mode <= mode_nxt;
        leds <= init_pat;
        cnt  <= '0;
        dir  <= DIR_L;
      end else if (!pause) begin
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + 25'd1;
        if (step) begin
          leds <= step_pat;
          dir  <= dir_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with a 4-clock step period: table of per-cycle
// vectors built from the mode sequences, plus literal corner-case sequences.
module tb_led_mode_ctrl;
  typedef struct {
    logic       rst;
    logic       nm;
    logic       pause;
    logic [3:0] leds;
    logic [1:0] mode;
    logic       tick;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       next_mode = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       tick;

  int n_chk = 0;
  int n_err = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  // reference sequences per mode, listed as the LED values appear on the board
  logic [3:0] seqtab [4][6];
  int         seqlen [4];
  logic [1:0] m_mode;
  int         m_idx;
  int         m_ph;
  logic       m_tick;

  led_mode_ctrl #(.CNT_TICK(3)) dut (
    .clk_50mhz(clk),
    .rst(rst),
    .next_mode(next_mode),
    .pause(pause),
    .leds(leds),
    .mode(mode),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic n, input logic p);
    vec_t v;
    if (r) begin
      m_mode = 2'd0; m_idx = 0; m_ph = 0; m_tick = 1'b0;
    end else if (n) begin
      m_mode = m_mode + 2'd1; m_idx = 0; m_ph = 0; m_tick = 1'b0;
    end else if (p) begin
      m_tick = 1'b0;
    end else if (m_ph == 3) begin
      m_ph = 0; m_idx = (m_idx + 1) % seqlen[m_mode]; m_tick = 1'b1;
    end else begin
      m_ph = m_ph + 1; m_tick = 1'b0;
    end
    v.rst = r; v.nm = n; v.pause = p;
    v.leds = seqtab[m_mode][m_idx]; v.mode = m_mode; v.tick = m_tick;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst = v.rst; next_mode = v.nm; pause = v.pause;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (leds !== e.leds) begin
      n_err++;
      $display("FAIL %s leds: got %b want %b", tag, leds, e.leds);
    end
    n_chk++;
    if (mode !== e.mode) begin
      n_err++;
      $display("FAIL %s mode: got %0d want %0d", tag, mode, e.mode);
    end
    n_chk++;
    if (tick !== e.tick) begin
      n_err++;
      $display("FAIL %s tick: got %b want %b", tag, tick, e.tick);
    end
  endtask

  task automatic hand(input logic r, input logic n, input logic p,
                      input logic [3:0] l, input logic [1:0] md, input logic t,
                      input string tag);
    vec_t v;
    v.rst = r; v.nm = n; v.pause = p; v.leds = l; v.mode = md; v.tick = t;
    cyc(v, tag);
  endtask

  initial begin
    seqtab[0] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    seqtab[1] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000, 4'b0000};
    seqtab[2] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0000, 4'b0000};
    seqtab[3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101};
    seqlen = '{2, 4, 4, 6};
    m_mode = 2'd0; m_idx = 0; m_ph = 0; m_tick = 1'b0;

    // reset then free-running flash
    add(1, 0, 0); idle(12);
    // one pulse: run left through a full lap
    add(0, 1, 0); idle(16);
    // three pulses 10 clocks apart from reset, then 8 bounce steps
    add(1, 0, 0);
    add(0, 1, 0); idle(9); add(0, 1, 0); idle(9); add(0, 1, 0); idle(32);
    // run right, pause held 10 clocks at cnt==2
    add(1, 0, 0); add(0, 1, 0); add(0, 1, 0); idle(2);
    for (int i = 0; i < 10; i++) add(0, 0, 1);
    idle(6);
    // reset while bouncing rightwards, then four pulses wrap the mode
    add(1, 0, 0); add(0, 1, 0); add(0, 1, 0); add(0, 1, 0); idle(21);
    add(1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0);
    idle(4);

    for (int i = 0; i < vecs.size(); i++) cyc(vecs[i], $sformatf("vec%0d", i));

    // next_mode on the terminal count: mode change only, period restarts
    hand(1, 0, 0, 4'b1111, 2'd0, 0, "tc_rst");
    for (int i = 0; i < 3; i++) hand(0, 0, 0, 4'b1111, 2'd0, 0, "tc_wait");
    hand(0, 1, 0, 4'b1110, 2'd1, 0, "tc_nm");
    for (int i = 0; i < 3; i++) hand(0, 0, 0, 4'b1110, 2'd1, 0, "tc_hold");
    hand(0, 0, 0, 4'b1101, 2'd1, 1, "tc_step");
    // pause held on the terminal count: step fires one clock after release
    for (int i = 0; i < 3; i++) hand(0, 0, 0, 4'b1101, 2'd1, 0, "pz_run");
    for (int i = 0; i < 3; i++) hand(0, 0, 1, 4'b1101, 2'd1, 0, "pz_hold");
    hand(0, 0, 0, 4'b1011, 2'd1, 1, "pz_rel");
    // next_mode is honoured under pause; reset overrides next_mode
    hand(0, 1, 1, 4'b0111, 2'd2, 0, "nm_pause");
    hand(1, 1, 1, 4'b1111, 2'd0, 0, "rst_over");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
